// File: rtl/branch_history_table.sv
// Branch history table: 2-bit saturating counters indexed by PC[IDXW+1:2], same-cycle lookup.
// Optional tagged target buffer enabled by defining BHT_BTB_EN.
module branch_history_table #(
  parameter int unsigned ENTRIES = 64
) (
  input  logic        iCLK,
  input  logic        iRST,
  input  logic [31:0] iFetchPC,
  output logic        oPredTaken,
  output logic [31:0] oPredTarget,
  input  logic        iUpdValid,
  input  logic [31:0] iUpdPC,
  input  logic        iUpdTaken,
  input  logic        iUpdPredicted,
  input  logic [31:0] iUpdTarget,
  output logic        oReady,
  output logic [31:0] oMispredictCount
);

  localparam int unsigned IDXW = $clog2(ENTRIES);
  localparam int unsigned TAGW = 32 - IDXW - 2;

  typedef enum logic {
    ST_INIT,
    ST_RUN
  } state_e;

  state_e          state_q, state_d;
  logic [IDXW-1:0] ptr_q, ptr_d;
  logic [31:0]     miss_q, miss_d;
  logic [1:0]      cnt_q [ENTRIES];

  logic [IDXW-1:0] fetch_idx, upd_idx;
  logic [1:0]      fetch_cnt, upd_cnt, upd_cnt_d;
  logic            run;
  logic            upd_en;

  assign fetch_idx = iFetchPC[IDXW+1:2];
  assign upd_idx   = iUpdPC[IDXW+1:2];
  assign fetch_cnt = cnt_q[fetch_idx];
  assign upd_cnt   = cnt_q[upd_idx];
  assign run       = (state_q == ST_RUN);
  assign upd_en    = run && iUpdValid;

  assign oReady           = run;
  assign oMispredictCount = miss_q;

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    miss_d  = miss_q;
    case (state_q)
      ST_INIT: begin
        ptr_d = ptr_q + IDXW'(1);
        if (ptr_q == IDXW'(ENTRIES - 1)) begin
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (iUpdValid && (iUpdTaken != iUpdPredicted) && (miss_q != '1)) begin
          miss_d = miss_q + 32'd1;
        end
      end
      default: state_d = ST_INIT;
    endcase
  end

  always_ff @(posedge iCLK) begin
    if (iRST) begin
      state_q <= ST_INIT;
      ptr_q   <= '0;
      miss_q  <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      miss_q  <= miss_d;
    end
  end

  always_comb begin
    upd_cnt_d = upd_cnt;
    if (iUpdTaken) begin
      if (upd_cnt != 2'b11) upd_cnt_d = upd_cnt + 2'd1;
    end else begin
      if (upd_cnt != 2'b00) upd_cnt_d = upd_cnt - 2'd1;
    end
  end

  // Table storage is not reset; the INIT sweep rewrites every entry instead.
  always_ff @(posedge iCLK) begin
    if (!iRST) begin
      if (state_q == ST_INIT) begin
        cnt_q[ptr_q] <= 2'b01;
      end else if (upd_en) begin
        cnt_q[upd_idx] <= upd_cnt_d;
      end
    end
  end

`ifdef BHT_BTB_EN
  logic            valid_q [ENTRIES];
  logic [TAGW-1:0] tag_q   [ENTRIES];
  logic [31:0]     tgt_q   [ENTRIES];
  logic            tag_hit;
  logic [3:0]      unused_pc_lsbs;

  assign unused_pc_lsbs = {iFetchPC[1:0], iUpdPC[1:0]};

  always_ff @(posedge iCLK) begin
    if (!iRST) begin
      if (state_q == ST_INIT) begin
        valid_q[ptr_q] <= 1'b0;
      end else if (upd_en && iUpdTaken) begin
        valid_q[upd_idx] <= 1'b1;
        tag_q[upd_idx]   <= iUpdPC[31:IDXW+2];
        tgt_q[upd_idx]   <= iUpdTarget;
      end
    end
  end

  assign tag_hit     = valid_q[fetch_idx] && (tag_q[fetch_idx] == iFetchPC[31:IDXW+2]);
  assign oPredTaken  = run && fetch_cnt[1] && tag_hit;
  assign oPredTarget = oPredTaken ? tgt_q[fetch_idx] : '0;
`else
  logic unused_inputs;

  assign unused_inputs = ^{iFetchPC[31:IDXW+2], iFetchPC[1:0],
                           iUpdPC[31:IDXW+2], iUpdPC[1:0], iUpdTarget};

  assign oPredTaken  = run && fetch_cnt[1];
  assign oPredTarget = '0;
`endif

endmodule

// File: doc/branch_history_table.md
# branch_history_table

Dynamic branch predictor for the RISC-V core, downstream of the branch comparator. It consumes each resolved branch outcome (taken / not-taken, plus the prediction that was made) and trains a table of 2-bit saturating counters indexed by branch PC. The fetch stage queries it with the current PC and gets a same-cycle taken/not-taken prediction. A cycle-accurate misprediction counter is exported for performance monitoring.

## Interface
- ENTRIES, 64: number of table entries; power of two, 4..1024; IDXW = log2(ENTRIES)
- iCLK  in  1  core clock, all state updates on rising edge
- iRST  in  1  synchronous reset, active-high
- iFetchPC  in  32  PC being fetched (lookup port)
- oPredTaken  out  1  prediction for iFetchPC; 1 = taken
- oPredTarget  out  32  predicted target (see Configuration)
- iUpdValid  in  1  a conditional branch resolved this cycle
- iUpdPC  in  32  PC of resolved branch
- iUpdTaken  in  1  actual outcome (comparator result)
- iUpdPredicted  in  1  prediction that was used for this branch
- iUpdTarget  in  32  computed branch target
- oReady  out  1  table initialisation complete
- oMispredictCount  out  32  number of counted mispredictions

## Operation
- Index = PC[IDXW+1:2] for both ports; PC[1:0] ignored.
- Counter encoding: 00 strong-NT, 01 weak-NT, 10 weak-T, 11 strong-T. Prediction = counter[1].
- FSM states: INIT, RUN.
  - iRST=1: state←INIT, sweep pointer←0, oMispredictCount←0. Table contents untouched that edge.
  - INIT: each edge writes entry[ptr]←01 (and clears BTB valid when enabled), ptr←ptr+1; on the edge where ptr==ENTRIES-1, state←RUN.
  - RUN: remains until iRST.
- During INIT: oReady=0, oPredTaken=0, oPredTarget=0, iUpdValid ignored (no training, no counting).
- In RUN with iUpdValid=1: counter at index increments if iUpdTaken=1, decrements otherwise; saturates at 11 / 00 (no wrap).
- Misprediction: iUpdValid=1 and iUpdTaken≠iUpdPredicted in RUN → oMispredictCount+1; saturates at 32'hFFFF_FFFF.
- Lookup and update to the same index in the same cycle: lookup returns pre-update value (read-before-write); new value visible the following cycle.
- Lookup and update to different indices: fully independent.
- Reset asserted mid-INIT or mid-RUN: restart sweep from 0; all outputs return to reset values next edge.

## Timing
- Reset values (edge after iRST=1): oReady=0, oPredTaken=0, oPredTarget=0, oMispredictCount=0.
- Lookup path combinational: oPredTaken/oPredTarget valid same cycle as iFetchPC.
- Update latency: 1 edge; counter and oMispredictCount registered.
- oReady rises exactly ENTRIES edges after the first edge with iRST=0 (ENTRIES=64 → 64 cycles).
- One update per cycle sustained; no backpressure.

## Configuration
- BHT_BTB_EN defined: each entry also stores valid bit, tag PC[31:IDXW+2] and 32-bit target. Update with iUpdTaken=1 writes tag, target, valid←1 (counter trained regardless). oPredTaken = counter[1] & valid & tag match; oPredTarget = stored target when oPredTaken=1, else 0.
- BHT_BTB_EN undefined: no tag/target storage; oPredTaken = counter[1]; oPredTarget tied to 32'h0 (fetch computes target after decode); iUpdTarget unused.

## Test plan
- Reset, ENTRIES=64: oReady=0 for 64 cycles, then 1; lookup of any PC returns oPredTaken=0; iUpdValid pulses during INIT leave counter and oMispredictCount unchanged.
- PC=0x0000_0040, three taken updates → counter 01→10→11→11; oPredTaken=1 from the cycle after the first update; then two not-taken → 10, 01, oPredTaken=0.
- Aliasing: updates at 0x0000_0040 taken; lookup 0x0000_0140 (same index) predicts taken without BTB, not taken with BHT_BTB_EN (tag miss).
- Same-cycle lookup/update at 0x0000_0080 from weak-NT with iUpdTaken=1: oPredTaken=0 that cycle, 1 next cycle.
- Misprediction counting: 5 updates with iUpdTaken≠iUpdPredicted, 3 equal → oMispredictCount=5; forced count 32'hFFFF_FFFF stays saturated on another mispredict.
- iRST mid-RUN after training: counters reinitialised, oReady low 64 cycles, oMispredictCount=0; with BHT_BTB_EN, oPredTarget=0 for all PCs afterward.
